flit_serializer: RTL and testbench
==================================

// Module: flit_serializer
// PURPOSE
//  Parallel-to-serial transmitter for the mesh serial link. Accepts N-bit words on a
//  valid/ready handshake and shifts them out one bit per clock, with a frame strobe.
//  Drives the receiving universal shift register directly:
//    o_frame -> S=2'b10 (left shift); o_serial -> left_in; o_last marks capture.
//  A one-entry hold buffer allows back-to-back words with no idle cycle on the link.
// PARAMETERS
//  N          8   word width in bits; N >= 2
//  LSB_FIRST  0   0: MSB first (matches a left-shifting receiver); 1: LSB first
// PORTS
//  clk       in   1  clock; all state updates on rising edge
//  reset     in   1  asynchronous, active-low reset
//  i_data    in   N  parallel word to transmit
//  i_valid   in   1  i_data is valid
//  o_ready   out  1  block can take a word this cycle
//  o_serial  out  1  serial data bit
//  o_frame   out  1  high for every cycle that o_serial carries a word bit
//  o_last    out  1  high on the final (Nth) bit of a word
//  o_busy    out  1  shifter or hold buffer occupied
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, shift reg=0, bit count=0, hold_valid=0.
//    While reset is low: o_serial=0, o_frame=0, o_last=0, o_busy=0, o_ready=0.
//  - o_ready = reset & ~hold_valid. This is combinational on the registered hold_valid.
//    It never depends on i_valid.
//  - Accept = i_valid & o_ready, sampled at the rising edge.
//  - FSM states:
//    IDLE -> SHIFT on an accept. The word loads straight into the shifter and cnt=0.
//    SHIFT: each edge shifts one bit and increments cnt.
//    On the edge where cnt==N-1 (the last bit):
//      hold_valid=1       -> load the hold word, clear hold_valid, cnt=0, stay in SHIFT.
//      accept this cycle  -> load i_data directly, cnt=0, stay in SHIFT.
//      neither            -> go to IDLE.
//    Accept in SHIFT with cnt!=N-1 -> i_data goes to the hold buffer; hold_valid=1.
//    With hold_valid=1, o_ready=0, so there is no accept.
//  - Latency: a word accepted at edge k puts its first bit on o_serial in the cycle
//    after edge k. Its last bit appears after edge k+N-1.
//  - Throughput: a continuous i_valid gives one word per N cycles.
//    o_frame stays high with no gaps.
//  - Outputs:
//    o_serial = shifter MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1); 0 in IDLE.
//    o_frame  = (state==SHIFT).
//    o_last   = SHIFT & (cnt==N-1).
//    o_busy   = o_frame | hold_valid.
//  - Widths: cnt is $clog2(N) bits and never exceeds N-1. Vacated shifter bits fill with 0.
//  - Holding i_data/i_valid while o_ready=0 has no effect. A word is never dropped or
//    duplicated.
//  - Reset mid-word: transmission aborts immediately and any held word is discarded.
//    After release the block is IDLE; the first bit of a new accept follows one cycle
//    later.
// STRUCTURE
//  - Shared package link_pkg:
//    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
//    localparam LINK_MSB_FIRST = 0.
//  - No sub-module is needed. The hold buffer (data + valid flag) stays inline.
//    Only the shifter, counter, FSM and hold register are present.
// TESTING (N=8 unless stated; receiver-model shift register connected)
//  1 Reset: hold reset low, drive i_valid=1 -> all outputs 0; o_ready=0; no frame
//    after release until an accept.
//  2 Single word 8'hA5, MSB first -> o_serial = 1,0,1,0,0,1,0,1 over 8 cycles;
//    o_last on cycle 8; receiver A = 8'hA5; then IDLE with o_frame=0.
//  3 Back-to-back 8'h3C, 8'hC3, 8'hFF with i_valid held high -> 24 contiguous
//    frame cycles; o_last on cycles 8/16/24; o_ready low while hold full.
//  4 Accept on the last-bit cycle with hold empty -> next word starts with no gap;
//    hold_valid stays 0.
//  5 Assert reset at bit 4 of 8'hF0 with 8'h0F held -> o_frame=0 immediately;
//    after release, a new word 8'h81 is sent cleanly and 8'h0F never appears.
//  6 LSB_FIRST=1, N=4, word 4'b1101 -> o_serial = 1,0,1,1; o_last on the 4th bit.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the mesh serial link: serializer FSM encoding and bit-order selector.
package link_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Value of the serializer LSB_FIRST parameter that selects MSB-first order.
  localparam bit LINK_MSB_FIRST = 1'b0;

endpackage

// File: rtl/flit_serializer.sv
// Parallel-to-serial link transmitter: valid/ready word intake, one bit per clock out,
// with a one-word hold buffer so consecutive words stream with no idle cycle.
module flit_serializer
  import link_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = LINK_MSB_FIRST
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_serial,
  output logic         o_frame,
  output logic         o_last,
  output logic         o_busy
);

  localparam int              CW       = $clog2(N);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  ser_state_t      state;
  logic [N-1:0]    shreg;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    hold_data;
  logic            hold_valid;

  logic            accept;
  logic            last_bit;
  logic [N-1:0]    shifted;

  assign o_ready  = reset & ~hold_valid;
  assign accept   = i_valid & o_ready;
  assign last_bit = (state == SER_SHIFT) && (cnt == CNT_LAST);
  assign shifted  = LSB_FIRST ? {1'b0, shreg[N-1:1]} : {shreg[N-2:0], 1'b0};

  // NOTE: every register below is updated with <= so all of them see the pre-edge values of
  // state, cnt and hold_valid; blocking assignments here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SER_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (accept) begin
            state <= SER_SHIFT;
            shreg <= i_data;
            cnt   <= '0;
          end
        end
        SER_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (hold_valid) begin
              shreg      <= hold_data;
              hold_valid <= 1'b0;
            end else if (accept) begin
              shreg <= i_data;
            end else begin
              state <= SER_IDLE;
              shreg <= '0;
            end
          end else begin
            shreg <= shifted;
            cnt   <= cnt + CW'(1);
            if (accept) hold_valid <= 1'b1;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

  // NOTE: hold_data has no reset on purpose; its contents are only ever consumed while
  // hold_valid is set, and hold_valid itself is reset.
  always_ff @(posedge clk) begin
    if (accept && (state == SER_SHIFT) && !last_bit) hold_data <= i_data;
  end

  assign o_frame  = (state == SER_SHIFT);
  assign o_serial = o_frame & (LSB_FIRST ? shreg[0] : shreg[N-1]);
  assign o_last   = last_bit;
  assign o_busy   = o_frame | hold_valid;

endmodule

// File: tb/tb_flit_serializer.sv
// Scoreboard bench for flit_serializer: an 8-bit MSB-first instance and a 4-bit LSB-first one.
module tb_flit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready, a_serial, a_frame, a_last, a_busy;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready, b_serial, b_frame, b_last, b_busy;

  flit_serializer #(.N(8), .LSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
    .o_serial(a_serial), .o_frame(a_frame), .o_last(a_last), .o_busy(a_busy)
  );

  flit_serializer #(.N(4), .LSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .o_serial(b_serial), .o_frame(b_frame), .o_last(b_last), .o_busy(b_busy)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  int         checks   = 0;
  int         failures = 0;
  exp_t       exp_a[$];
  exp_t       exp_b[$];
  exp_t       ea, eb;
  logic [7:0] got_a[$];
  logic [3:0] got_b[$];
  logic [7:0] rx_a = '0;
  logic [3:0] rx_b = '0;
  int         frame_run = 0;
  int         max_run   = 0;
  int         last_pos[$];

  // Receiver models and scoreboard pop, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      rx_a      = '0;
      rx_b      = '0;
      frame_run = 0;
    end
    if (a_frame) begin
      frame_run++;
      if (frame_run > max_run) max_run = frame_run;
      rx_a = {rx_a[6:0], a_serial};
      if (a_last) begin
        last_pos.push_back(frame_run);
        got_a.push_back(rx_a);
      end
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_bit: got serial=%0b last=%0b, required no frame", a_serial, a_last);
      end else begin
        ea = exp_a.pop_front();
        if (a_serial !== ea.b || a_last !== ea.last) begin
          failures++;
          $display("FAIL a_bit: got serial=%0b last=%0b, required serial=%0b last=%0b",
                   a_serial, a_last, ea.b, ea.last);
        end
      end
    end else begin
      frame_run = 0;
    end
    if (b_frame) begin
      rx_b = {b_serial, rx_b[3:1]};
      if (b_last) got_b.push_back(rx_b);
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_bit: got serial=%0b last=%0b, required no frame", b_serial, b_last);
      end else begin
        eb = exp_b.pop_front();
        if (b_serial !== eb.b || b_last !== eb.last) begin
          failures++;
          $display("FAIL b_bit: got serial=%0b last=%0b, required serial=%0b last=%0b",
                   b_serial, b_last, eb.b, eb.last);
        end
      end
    end
  end

  task automatic push_a(input logic [7:0] d);
    exp_t e;
    for (int j = 7; j >= 0; j--) begin
      e.b    = d[j];
      e.last = (j == 0);
      exp_a.push_back(e);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    bit rdy;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      a_data  = d;
      a_valid = 1'b1;
      rdy     = a_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        push_a(d);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL a_accept_timeout: word %0h never accepted, required acceptance", d);
    end
  endtask

  task automatic send_b(input logic [3:0] d);
    bit   rdy;
    bit   done = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      b_data  = d;
      b_valid = 1'b1;
      rdy     = b_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        for (int j = 0; j < 4; j++) begin
          e.b    = d[j];
          e.last = (j == 3);
          exp_b.push_back(e);
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL b_accept_timeout: word %0h never accepted, required acceptance", d);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    #1;
    while ((exp_a.size() != 0 || a_frame || exp_b.size() != 0 || b_frame) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_a.size() != 0 || a_frame || exp_b.size() != 0 || b_frame) begin
      failures++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d frame_a=%0b, required empty and idle",
               exp_a.size(), exp_b.size(), a_frame);
    end
  endtask

  task automatic clear_logs();
    got_a.delete();
    got_b.delete();
    last_pos.delete();
    max_run = 0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hA5;
    b_valid = 1'b1;
    b_data  = 4'hD;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_serial !== 1'b0) begin failures++; $display("FAIL rst_serial: got %0b, required 0", a_serial); end
    checks++; if (a_frame  !== 1'b0) begin failures++; $display("FAIL rst_frame: got %0b, required 0", a_frame); end
    checks++; if (a_last   !== 1'b0) begin failures++; $display("FAIL rst_last: got %0b, required 0", a_last); end
    checks++; if (a_busy   !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b, required 0", a_busy); end
    checks++; if (a_ready  !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0b, required 0", a_ready); end
    checks++; if (b_ready  !== 1'b0) begin failures++; $display("FAIL rst_ready_b: got %0b, required 0", b_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_frame !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL post_rst_idle: got frame=%0b busy=%0b, required 0 0", a_frame, a_busy); end
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %0b, required 1", a_ready); end
  endtask

  task automatic test_single_word();
    clear_logs();
    send_a(8'hA5);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    checks++; if (a_frame !== 1'b1 || a_serial !== 1'b1) begin failures++; $display("FAIL single_first_bit: got frame=%0b serial=%0b, required 1 1", a_frame, a_serial); end
    drain(40);
    checks++; if (got_a.size() != 1 || got_a[0] !== 8'hA5) begin failures++; $display("FAIL single_rx_word: got count=%0d, required one word A5", got_a.size()); end
    checks++; if (last_pos.size() != 1 || last_pos[0] != 8) begin failures++; $display("FAIL single_last_pos: got count=%0d, required last on bit 8", last_pos.size()); end
    checks++; if (a_frame !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL single_idle: got frame=%0b busy=%0b ready=%0b, required 0 0 1", a_frame, a_busy, a_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words = '{8'h3C, 8'hC3, 8'hFF};
    clear_logs();
    send_a(words[0]);
    send_a(words[1]);
    @(negedge clk);
    #1;
    checks++; if (a_ready !== 1'b0 || a_busy !== 1'b1) begin failures++; $display("FAIL b2b_hold_full: got ready=%0b busy=%0b, required 0 1", a_ready, a_busy); end
    send_a(words[2]);
    @(negedge clk);
    a_valid = 1'b0;
    drain(60);
    checks++; if (max_run != 24) begin failures++; $display("FAIL b2b_contiguous: got run=%0d, required 24", max_run); end
    checks++; if (last_pos.size() != 3) begin failures++; $display("FAIL b2b_last_count: got %0d, required 3", last_pos.size()); end
    for (int i = 0; i < 3 && i < last_pos.size(); i++) begin
      checks++; if (last_pos[i] != 8 * (i + 1)) begin failures++; $display("FAIL b2b_last_pos: got %0d, required %0d", last_pos[i], 8 * (i + 1)); end
    end
    checks++; if (got_a.size() != 3) begin failures++; $display("FAIL b2b_word_count: got %0d, required 3", got_a.size()); end
    for (int i = 0; i < 3 && i < got_a.size(); i++) begin
      checks++; if (got_a[i] !== words[i]) begin failures++; $display("FAIL b2b_rx_word: got %0h, required %0h", got_a[i], words[i]); end
    end
  endtask

  task automatic test_last_cycle_accept();
    clear_logs();
    send_a(8'h5A);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (a_last !== 1'b1 || a_ready !== 1'b1) begin failures++; $display("FAIL lastacc_window: got last=%0b ready=%0b, required 1 1", a_last, a_ready); end
    a_data  = 8'h96;
    a_valid = 1'b1;
    @(posedge clk);
    push_a(8'h96);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b1) begin failures++; $display("FAIL lastacc_hold_empty: got ready=%0b busy=%0b, required 1 1", a_ready, a_busy); end
    checks++; if (a_frame !== 1'b1 || a_serial !== 1'b1) begin failures++; $display("FAIL lastacc_no_gap: got frame=%0b serial=%0b, required 1 1", a_frame, a_serial); end
    drain(40);
    checks++; if (max_run != 16) begin failures++; $display("FAIL lastacc_contiguous: got run=%0d, required 16", max_run); end
    checks++; if (got_a.size() != 2 || got_a[0] !== 8'h5A || got_a[1] !== 8'h96) begin failures++; $display("FAIL lastacc_rx_words: got count=%0d, required 5A then 96", got_a.size()); end
  endtask

  task automatic test_reset_mid_word();
    clear_logs();
    send_a(8'hF0);
    send_a(8'h0F);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_a.delete();
    checks++; if (a_frame !== 1'b0 || a_serial !== 1'b0 || a_last !== 1'b0) begin failures++; $display("FAIL midrst_outputs: got frame=%0b serial=%0b last=%0b, required 0 0 0", a_frame, a_serial, a_last); end
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL midrst_flags: got busy=%0b ready=%0b, required 0 0", a_busy, a_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (a_frame !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL midrst_released: got frame=%0b busy=%0b ready=%0b, required 0 0 1", a_frame, a_busy, a_ready); end
    send_a(8'h81);
    @(negedge clk);
    a_valid = 1'b0;
    drain(40);
    checks++; if (got_a.size() != 1 || got_a[0] !== 8'h81) begin failures++; $display("FAIL midrst_rx_word: got count=%0d, required one word 81", got_a.size()); end
  endtask

  task automatic test_lsb_first();
    clear_logs();
    send_b(4'b1101);
    @(negedge clk);
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (b_last !== 1'b1 || b_serial !== 1'b1) begin failures++; $display("FAIL lsb_last_bit: got last=%0b serial=%0b, required 1 1", b_last, b_serial); end
    drain(20);
    checks++; if (got_b.size() != 1 || got_b[0] !== 4'b1101) begin failures++; $display("FAIL lsb_rx_word: got count=%0d, required one word D", got_b.size()); end
    checks++; if (b_frame !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL lsb_idle: got frame=%0b busy=%0b, required 0 0", b_frame, b_busy); end
  endtask

  initial begin
    reset   = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_last_cycle_accept();
    test_reset_mid_word();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
